// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner, debouncer and 4-digit entry buffer.
//
// Ports:
//   clk           in  1   1 kHz system clock
//   reset         in  1   asynchronous, active-high
//   keyPad_row    in  4   row lines, active-low, asynchronous
//   keyPad_column out 4   column drive, one-hot active-low
//   Digits        out 16  entry buffer, [3:0] is the newest digit
//   Valid         out 4   per-nibble valid for Digits
//   key_strobe    out 1   one-cycle pulse per accepted key
//   key_code      out 4   code of the last accepted key
//   submit        out 1   one-cycle pulse when '#' is accepted
//   submit_code   out 16  Digits captured at submit
//   submit_valid  out 4   Valid captured at submit
module keypad_entry #(
    parameter int unsigned DEBOUNCE = 20,
    parameter int unsigned DWELL    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  keyPad_row,
    output logic [3:0]  keyPad_column,
    output logic [15:0] Digits,
    output logic [3:0]  Valid,
    output logic        key_strobe,
    output logic [3:0]  key_code,
    output logic        submit,
    output logic [15:0] submit_code,
    output logic [3:0]  submit_valid
);

    localparam logic [1:0] S_SCAN  = 2'd0;
    localparam logic [1:0] S_DEB   = 2'd1;
    localparam logic [1:0] S_PRESS = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);

    localparam logic [3:0] K_BKSP  = 4'hE;
    localparam logic [3:0] K_CLEAR = 4'hC;
    localparam logic [3:0] K_SUB   = 4'hF;

    logic [3:0] row_s1;
    logic [3:0] rs;
    logic [1:0] state;
    logic [1:0] col;
    logic [1:0] row_idx;
    logic [7:0] cnt;
    logic [7:0] dwell;

    logic       any_low;
    logic [1:0] low_idx;
    logic       dwell_done;
    logic       same_row;
    logic       accept;
    logic [1:0] acc_row;
    logic [3:0] acc_code;
    logic       is_digit;

    // Position (row, column) to key code.
    function automatic logic [3:0] decode(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = 4'hE;
            4'hD:    k = 4'h0;
            4'hE:    k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer; idles high so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1 <= 4'hF;
            rs     <= 4'hF;
        end else begin
            row_s1 <= keyPad_row;
            rs     <= row_s1;
        end
    end

    // Lowest-index low row wins.
    always_comb begin
        low_idx = 2'd0;
        if (!rs[0]) begin
            low_idx = 2'd0;
        end else if (!rs[1]) begin
            low_idx = 2'd1;
        end else if (!rs[2]) begin
            low_idx = 2'd2;
        end else if (!rs[3]) begin
            low_idx = 2'd3;
        end
    end

    assign any_low    = (rs != 4'hF);
    assign dwell_done = (dwell == DWELL_LAST);
    assign same_row   = any_low && (low_idx == row_idx);

    // A single-cycle debounce accepts straight from the scan sample.
    always_comb begin
        accept = 1'b0;
        if (state == S_SCAN) begin
            accept = dwell_done && any_low && (DEBOUNCE == 1);
        end else if (state == S_DEB) begin
            accept = same_row && (cnt == DEB_LAST);
        end
    end

    assign acc_row  = (state == S_SCAN) ? low_idx : row_idx;
    assign acc_code = decode(acc_row, col);
    assign is_digit = (acc_code <= 4'h9);

    assign keyPad_column = ~(4'b0001 << col);

    // Scan / debounce / release sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_SCAN;
            col     <= 2'd0;
            row_idx <= 2'd0;
            cnt     <= 8'd0;
            dwell   <= 8'd0;
        end else begin
            case (state)
                S_SCAN: begin
                    if (dwell_done) begin
                        dwell <= 8'd0;
                        if (any_low) begin
                            row_idx <= low_idx;
                            cnt     <= 8'd1;
                            state   <= accept ? S_PRESS : S_DEB;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
                S_DEB: begin
                    if (same_row) begin
                        if (accept) begin
                            state <= S_PRESS;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        // Bounce: give up and retry on the next visit.
                        state <= S_SCAN;
                        col   <= col + 2'd1;
                        dwell <= 8'd0;
                    end
                end
                S_PRESS: begin
                    state <= S_REL;
                    cnt   <= 8'd0;
                end
                default: begin
                    if (rs == 4'hF) begin
                        if (cnt == DEB_LAST) begin
                            state <= S_SCAN;
                            col   <= col + 2'd1;
                            dwell <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        cnt <= 8'd0;
                    end
                end
            endcase
        end
    end

    // Buffer and strobes change on the edge entering PRESS, so they are
    // already valid while key_strobe is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_strobe   <= 1'b0;
            key_code     <= 4'h0;
            submit       <= 1'b0;
            Digits       <= 16'h0;
            Valid        <= 4'h0;
            submit_code  <= 16'h0;
            submit_valid <= 4'h0;
        end else begin
            key_strobe <= accept;
            submit     <= 1'b0;
            if (accept) begin
                key_code <= acc_code;
                unique case (1'b1)
                    is_digit: begin
                        if (Valid != 4'hF) begin
                            Digits <= {Digits[11:0], acc_code};
                            Valid  <= {Valid[2:0], 1'b1};
                        end
                    end
                    (acc_code == K_BKSP): begin
                        Digits <= {4'h0, Digits[15:4]};
                        Valid  <= {1'b0, Valid[3:1]};
                    end
                    (acc_code == K_CLEAR): begin
                        Digits <= 16'h0;
                        Valid  <= 4'h0;
                    end
                    (acc_code == K_SUB): begin
                        submit       <= 1'b1;
                        submit_code  <= Digits;
                        submit_valid <= Valid;
                        Digits       <= 16'h0;
                        Valid        <= 4'h0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: self-checking bench for keypad_entry.
// Models a 4x4 switch matrix; scoreboard checks every accepted key.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  keyPad_row;
    logic [3:0]  keyPad_column;
    logic [15:0] Digits;
    logic [3:0]  Valid;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic        submit;
    logic [15:0] submit_code;
    logic [3:0]  submit_valid;

    logic [15:0] pressed = 16'h0;

    typedef struct {
        logic [3:0]  key;
        logic [3:0]  code;
        logic [15:0] dig;
        logic [3:0]  vld;
        logic        sub;
        logic [15:0] scode;
        logic [3:0]  svld;
    } vec_t;

    vec_t tbl[13];
    vec_t sbq[$];
    vec_t mon_e;

    int errors = 0;
    int checks = 0;
    int n_strobe = 0;

    keypad_entry dut (
        .clk          (clk),
        .reset        (reset),
        .keyPad_row   (keyPad_row),
        .keyPad_column(keyPad_column),
        .Digits       (Digits),
        .Valid        (Valid),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .submit       (submit),
        .submit_code  (submit_code),
        .submit_valid (submit_valid)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is low.
    always_comb begin
        logic [3:0] ix;
        keyPad_row = 4'hF;
        ix = 4'h0;
        for (int i = 0; i < 16; i++) begin
            ix = i[3:0];
            if (pressed[ix] && !keyPad_column[ix[1:0]])
                keyPad_row[ix[3:2]] = 1'b0;
        end
    end

    function automatic logic [3:0] pos(input logic [3:0] k);
        case (k)
            4'h1: return 4'd0;
            4'h2: return 4'd1;
            4'h3: return 4'd2;
            4'hA: return 4'd3;
            4'h4: return 4'd4;
            4'h5: return 4'd5;
            4'h6: return 4'd6;
            4'hB: return 4'd7;
            4'h7: return 4'd8;
            4'h8: return 4'd9;
            4'h9: return 4'd10;
            4'hC: return 4'd11;
            4'hE: return 4'd12;
            4'h0: return 4'd13;
            4'hF: return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe pops one expected record.
    always @(posedge clk) begin
        #1;
        if (submit && !key_strobe) begin
            checks++;
            errors++;
            $display("FAIL submit_without_strobe: got 1 expected 0");
        end
        if (key_strobe) begin
            n_strobe++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: code %h expected none",
                         key_code);
            end else begin
                mon_e = sbq.pop_front();
                chk("key_code", key_code, mon_e.code);
                chk("Digits", Digits, mon_e.dig);
                chk("Valid", Valid, mon_e.vld);
                chk("submit", submit, mon_e.sub);
                chk("submit_code", submit_code, mon_e.scode);
                chk("submit_valid", submit_valid, mon_e.svld);
            end
        end
    end

    // Hold mask until a strobe appears (bounded), hold more, release.
    task automatic press_mask(input logic [15:0] m, input int hold);
        int base;
        bit got;
        base = n_strobe;
        got = 1'b0;
        pressed = m;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (n_strobe != base) got = 1'b1;
        end
        chk("press_seen", 32'(got), 32'd1);
        repeat (hold) @(negedge clk);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        chk("one_strobe", n_strobe - base, 32'd1);
    endtask

    task automatic apply(input vec_t v, input int hold);
        logic [15:0] m;
        m = 16'h1 << pos(v.key);
        sbq.push_back(v);
        press_mask(m, hold);
    endtask

    initial begin
        vec_t v;
        logic [3:0] ec;
        int base;
        int run;

        tbl[0]  = '{4'hF, 4'hF, 16'h0000, 4'h0, 1'b1, 16'h0000, 4'h0};
        tbl[1]  = '{4'h1, 4'h1, 16'h0001, 4'h1, 1'b0, 16'h0000, 4'h0};
        tbl[2]  = '{4'h2, 4'h2, 16'h0012, 4'h3, 1'b0, 16'h0000, 4'h0};
        tbl[3]  = '{4'h3, 4'h3, 16'h0123, 4'h7, 1'b0, 16'h0000, 4'h0};
        tbl[4]  = '{4'h4, 4'h4, 16'h1234, 4'hF, 1'b0, 16'h0000, 4'h0};
        tbl[5]  = '{4'h5, 4'h5, 16'h1234, 4'hF, 1'b0, 16'h0000, 4'h0};
        tbl[6]  = '{4'hE, 4'hE, 16'h0123, 4'h7, 1'b0, 16'h0000, 4'h0};
        tbl[7]  = '{4'hF, 4'hF, 16'h0000, 4'h0, 1'b1, 16'h0123, 4'h7};
        tbl[8]  = '{4'hC, 4'hC, 16'h0000, 4'h0, 1'b0, 16'h0123, 4'h7};
        tbl[9]  = '{4'hE, 4'hE, 16'h0000, 4'h0, 1'b0, 16'h0123, 4'h7};
        tbl[10] = '{4'hA, 4'hA, 16'h0000, 4'h0, 1'b0, 16'h0123, 4'h7};
        tbl[11] = '{4'h5, 4'h5, 16'h0005, 4'h1, 1'b0, 16'h0123, 4'h7};
        tbl[12] = '{4'h6, 4'h6, 16'h0056, 4'h3, 1'b0, 16'h0123, 4'h7};

        repeat (3) @(negedge clk);
        chk("rst_column", keyPad_column, 4'b1110);
        chk("rst_Digits", Digits, 16'h0);
        chk("rst_Valid", Valid, 4'h0);
        chk("rst_key_code", key_code, 4'h0);
        chk("rst_strobe", key_strobe, 1'b0);
        chk("rst_submit", submit, 1'b0);

        // Idle scan: each column held 4 cycles.
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            ec = ~(4'b0001 << (i / 4));
            chk("idle_column", keyPad_column, ec);
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("idle_strobes", n_strobe, 32'd0);
        chk("idle_Digits", Digits, 16'h0);
        chk("idle_Valid", Valid, 4'h0);

        for (int i = 0; i < 8; i++) apply(tbl[i], 10);

        // Bounce then steady press of '1'.
        v = '{4'h1, 4'h1, 16'h0001, 4'h1, 1'b0, 16'h0123, 4'h7};
        sbq.push_back(v);
        base = n_strobe;
        repeat (5) begin
            pressed = (pressed == 16'h0) ? 16'h0001 : 16'h0000;
            repeat (3) @(negedge clk);
        end
        chk("bounce_no_strobe", n_strobe - base, 32'd0);
        press_mask(16'h0001, 30);

        // Long hold of '2'.
        v = '{4'h2, 4'h2, 16'h0012, 4'h3, 1'b0, 16'h0123, 4'h7};
        apply(v, 200);

        // Keys 4 and 7 together: lower row wins.
        v = '{4'h4, 4'h4, 16'h0124, 4'h7, 1'b0, 16'h0123, 4'h7};
        sbq.push_back(v);
        press_mask(16'h0110, 10);

        for (int i = 8; i < 13; i++) apply(tbl[i], 10);

        // Reset in the middle of debouncing key 7.
        pressed = 16'h0100;
        run = 0;
        for (int i = 0; i < 100 && run < 8; i++) begin
            @(negedge clk);
            if (keyPad_column == 4'b1110) run++;
            else run = 0;
        end
        chk("deb_reached", 32'(run >= 8), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_column", keyPad_column, 4'b1110);
        chk("arst_Digits", Digits, 16'h0);
        chk("arst_Valid", Valid, 4'h0);
        chk("arst_key_code", key_code, 4'h0);
        chk("arst_submit_code", submit_code, 16'h0);
        chk("arst_submit_valid", submit_valid, 4'h0);
        v = '{4'h7, 4'h7, 16'h0007, 4'h1, 1'b0, 16'h0000, 4'h0};
        sbq.push_back(v);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        press_mask(16'h0100, 10);

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
